// File: rtl/sipo_receiver_if.sv
// Bus bundle for sipo_receiver: serial strobe/data/sync inputs plus the
// buffered word, its valid/ready handshake and the status flags.
interface sipo_receiver_if #(
    parameter int WIDTH = 8
);
    logic             enable;
    logic             serial_in;
    logic             sync;
    logic             data_ready;
    logic [WIDTH-1:0] shift_reg;
    logic [WIDTH-1:0] data_out;
    logic             data_valid;
    logic             overrun;
    logic             busy;
    logic             parity_err;

    modport master (
        output enable, serial_in, sync, data_ready,
        input  shift_reg, data_out, data_valid, overrun, busy, parity_err
    );

    modport slave (
        input  enable, serial_in, sync, data_ready,
        output shift_reg, data_out, data_valid, overrun, busy, parity_err
    );
endinterface

// File: rtl/sipo_receiver.sv
// Serial-in parallel-out receiver, MSB first, with a one-entry valid/ready buffer.
// Define PARITY_CHECK_EN to append a trailing even-parity bit to every frame.
module sipo_receiver #(
    parameter int WIDTH = 8
) (
    input  logic            clk,
    input  logic            reset,
    sipo_receiver_if.slave  bus
);
`ifdef PARITY_CHECK_EN
    localparam int FRAME_LEN = WIDTH + 1;
`else
    localparam int FRAME_LEN = WIDTH;
`endif
    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] shift_reg;
    logic [CW-1:0]    bit_cnt;
    logic [WIDTH-1:0] data_out;
    logic             data_valid;
    logic             overrun;
    logic             last_bit;
    logic             complete;
    logic             load;
    logic [WIDTH-1:0] word;

    assign last_bit = (bit_cnt == CW'(FRAME_LEN - 1));
    assign complete = bus.enable && !bus.sync && last_bit;
    assign load     = complete && (!data_valid || bus.data_ready);

`ifdef PARITY_CHECK_EN
    // The parity bit is never shifted in, so the word is already complete.
    assign word = shift_reg;
`else
    assign word = {shift_reg[WIDTH-2:0], bus.serial_in};
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shift_reg  <= '0;
            bit_cnt    <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (bus.sync) begin
                shift_reg <= '0;
                bit_cnt   <= '0;
                overrun   <= 1'b0;
            end else if (bus.enable) begin
                if (last_bit) begin
                    shift_reg <= '0;
                    bit_cnt   <= '0;
                end else begin
                    shift_reg <= {shift_reg[WIDTH-2:0], bus.serial_in};
                    bit_cnt   <= bit_cnt + CW'(1);
                end
            end

            // A completing word either refills the buffer or is dropped as overrun.
            if (complete) begin
                if (load) begin
                    data_out   <= word;
                    data_valid <= 1'b1;
                end else begin
                    overrun    <= 1'b1;
                end
            end else if (data_valid && bus.data_ready) begin
                data_valid <= 1'b0;
            end
        end
    end

`ifdef PARITY_CHECK_EN
    logic parity_err;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            parity_err <= 1'b0;
        else if (load)
            parity_err <= (^word) ^ bus.serial_in;
    end

    assign bus.parity_err = parity_err;
`else
    assign bus.parity_err = 1'b0;
`endif

    assign bus.shift_reg  = shift_reg;
    assign bus.data_out   = data_out;
    assign bus.data_valid = data_valid;
    assign bus.overrun    = overrun;
    assign bus.busy       = (bit_cnt != '0);
endmodule
